// File: rtl/sid_seq_pkg.sv
// Shared types for the SID register sequencer: opcodes, program entry layout
// and the width of the clk_en tick counter.
package sid_seq_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_WAIT  = 2'b01,
    OP_JUMP  = 2'b10,
    OP_END   = 2'b11
  } sid_op_e;

  localparam int ENTRY_W = 15;
  localparam int TICK_W  = 13;

  // One program entry: [14:13] op, [12:8] addr, [7:0] data.
  typedef struct packed {
    sid_op_e    op;
    logic [4:0] addr;
    logic [7:0] data;
  } sid_entry_t;

endpackage

// File: rtl/sid_seq_timer.sv
// clk_en tick down-counter shared by the post-write gap and WAIT entries.
// A load always wins over a coincident tick; the count parks at zero.
module sid_seq_timer
  import sid_seq_pkg::*;
(
  input  logic              clk,
  input  logic              n_reset,
  input  logic              load,
  input  logic [TICK_W-1:0] load_val,
  input  logic              tick,
  output logic              zero
);

  logic [TICK_W-1:0] count_reg;

  // Load a new count, otherwise step down once per clk_en tick until empty.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (tick && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/sid_reg_sequencer.sv
// Runs a small program of SID register writes, waits and jumps, pacing the
// SID chip-select pulses on the 1 MHz clk_en strobe.
module sid_reg_sequencer
  import sid_seq_pkg::*;
#(
  parameter  int DEPTH     = 16,
  parameter  int WRITE_GAP = 1000,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               clk_en,
  input  logic               start,
  input  logic               stop,
  input  logic               load_en,
  input  logic [IDX_W-1:0]   load_idx,
  input  logic [ENTRY_W-1:0] load_word,
  output logic [4:0]         sid_addr,
  output logic [7:0]         sid_data,
  output logic               sid_n_cs,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   pc
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_GAP,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [8:0]        DEPTH_EXT = 9'(DEPTH);
  localparam logic [TICK_W-1:0] GAP_TICKS = TICK_W'(WRITE_GAP);

  state_e             state_reg, state_next;
  logic [IDX_W-1:0]   pc_reg, pc_next;
  logic [4:0]         sid_addr_reg, sid_addr_next;
  logic [7:0]         sid_data_reg, sid_data_next;
  logic               n_cs_reg, n_cs_next;
  logic               timer_load;
  logic [TICK_W-1:0]  timer_val;
  logic               timer_zero;
  logic [ENTRY_W-1:0] prog_mem [DEPTH];
  logic [ENTRY_W-1:0] rd_word_reg;
  sid_entry_t         rd_entry;
  logic               load_ok;
  logic               at_last;

  assign rd_entry = sid_entry_t'(rd_word_reg);
  assign load_ok  = load_en && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign at_last  = (pc_reg == LAST_IDX);

  // Program table: loads only while stopped; the read follows pc_next so FETCH
  // already holds table[pc], with a write-first bypass for a load on the start edge.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      prog_mem[load_idx] <= load_word;
    end
    if (load_ok && (load_idx == pc_next)) begin
      rd_word_reg <= load_word;
    end else begin
      rd_word_reg <= prog_mem[pc_next];
    end
  end

  sid_seq_timer u_timer (
    .clk      (clk),
    .n_reset  (n_reset),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     (clk_en),
    .zero     (timer_zero)
  );

  // Next-state logic: dispatch fetched entries, pace writes and waits, stop overrides all.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    sid_addr_next = sid_addr_reg;
    sid_data_next = sid_data_reg;
    n_cs_next     = n_cs_reg;
    timer_load    = 1'b0;
    timer_val     = '0;
    unique case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pc_next    = '0;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        case (rd_entry.op)
          OP_WRITE: begin
            sid_addr_next = rd_entry.addr;
            sid_data_next = rd_entry.data;
            n_cs_next     = 1'b0;
            state_next    = ST_WRITE;
          end
          OP_WAIT: begin
            timer_load = 1'b1;
            timer_val  = {rd_entry.addr, rd_entry.data};
            state_next = ST_WAIT;
          end
          OP_JUMP: begin
            if ({1'b0, rd_entry.data} >= DEPTH_EXT) begin
              state_next = ST_DONE;
            end else begin
              pc_next    = rd_entry.data[IDX_W-1:0];
              state_next = ST_FETCH;
            end
          end
          OP_END: begin
            state_next = ST_DONE;
          end
        endcase
      end
      ST_WRITE: begin
        // Chip select stays low through the tick edge so the SID samples it.
        if (clk_en) begin
          n_cs_next  = 1'b1;
          timer_load = 1'b1;
          timer_val  = GAP_TICKS;
          state_next = ST_GAP;
        end
      end
      ST_GAP, ST_WAIT: begin
        if (timer_zero) begin
          if (at_last) begin
            state_next = ST_DONE;
          end else begin
            pc_next    = pc_reg + 1'b1;
            state_next = ST_FETCH;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (stop) begin
      state_next    = ST_IDLE;
      pc_next       = pc_reg;
      sid_addr_next = sid_addr_reg;
      sid_data_next = sid_data_reg;
      n_cs_next     = 1'b1;
    end
  end

  // Sequencer state and registered SID bus; reset releases chip select at once.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= '0;
      sid_addr_reg <= '0;
      sid_data_reg <= '0;
      n_cs_reg     <= 1'b1;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      sid_addr_reg <= sid_addr_next;
      sid_data_reg <= sid_data_next;
      n_cs_reg     <= n_cs_next;
    end
  end

  assign sid_addr = sid_addr_reg;
  assign sid_data = sid_data_reg;
  assign sid_n_cs = n_cs_reg;
  assign pc       = pc_reg;
  assign busy     = state_reg inside {ST_FETCH, ST_WRITE, ST_GAP, ST_WAIT};
  assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_sid_reg_sequencer.sv
// Bench for the SID register sequencer: random clk_en spacing, programs run
// against an entry-level model that predicts each write's tick index.
module tb_sid_reg_sequencer;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam int IDX_W = $clog2(DEPTH);

  logic             clk       = 1'b0;
  logic             n_reset   = 1'b1;
  logic             clk_en    = 1'b0;
  logic             start     = 1'b0;
  logic             stop      = 1'b0;
  logic             load_en   = 1'b0;
  logic [IDX_W-1:0] load_idx  = '0;
  logic [14:0]      load_word = '0;
  logic [4:0]       sid_addr;
  logic [7:0]       sid_data;
  logic             sid_n_cs;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] pc;

  int   total_cnt = 0;
  int   bad_cnt   = 0;
  int   tick_cnt  = 0;
  int   tick_base = 0;
  int   en_gap    = 0;
  bit   mon_on    = 1'b0;
  logic n_cs_prev = 1'b1;
  int   cap_addr[$], cap_data[$], cap_tick[$];
  int   exp_addr[$], exp_data[$], exp_tick[$];
  int   exp_pc, exp_end_tick;
  logic [14:0] model_prog [DEPTH];

  sid_reg_sequencer #(.DEPTH(DEPTH), .WRITE_GAP(GAP)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .clk_en    (clk_en),
    .start     (start),
    .stop      (stop),
    .load_en   (load_en),
    .load_idx  (load_idx),
    .load_word (load_word),
    .sid_addr  (sid_addr),
    .sid_data  (sid_data),
    .sid_n_cs  (sid_n_cs),
    .busy      (busy),
    .done      (done),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  // clk_en: one-cycle strobe every 6..9 clocks; tick_cnt counts consumed strobes
  initial forever begin
    @(posedge clk);
    #1;
    if (clk_en) tick_cnt++;
    if (en_gap == 0) begin
      clk_en = 1'b1;
      en_gap = $urandom_range(5, 8);
    end else begin
      clk_en = 1'b0;
      en_gap--;
    end
  end

  // capture each chip-select pulse end with the bus value and tick index
  initial forever begin
    @(negedge clk);
    if (mon_on && n_cs_prev === 1'b0 && sid_n_cs === 1'b1) begin
      cap_addr.push_back(int'(sid_addr));
      cap_data.push_back(int'(sid_data));
      cap_tick.push_back(tick_cnt - tick_base);
    end
    n_cs_prev = sid_n_cs;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] enc(input logic [1:0] op, input logic [4:0] a, input logic [7:0] d);
    return {op, a, d};
  endfunction

  // Entry-level interpretation: a write ends on the next tick, then GAP ticks;
  // WAIT n consumes n ticks; JUMP/END consume none.
  task automatic model_run(input int max_writes);
    int t, p, steps, op, a, d;
    bit fin;
    exp_addr.delete(); exp_data.delete(); exp_tick.delete();
    t = 0; p = 0; steps = 0; fin = 1'b0;
    while (!fin && steps < 1000 && exp_addr.size() < max_writes) begin
      op = int'(model_prog[p][14:13]);
      a  = int'(model_prog[p][12:8]);
      d  = int'(model_prog[p][7:0]);
      steps++;
      if (op == 3) begin
        fin = 1'b1;
      end else if (op == 2) begin
        if (d >= DEPTH) fin = 1'b1;
        else p = d;
      end else begin
        if (op == 0) begin
          t = t + 1;
          exp_addr.push_back(a); exp_data.push_back(d); exp_tick.push_back(t);
          t = t + GAP;
        end else begin
          t = t + int'(model_prog[p][12:0]);
        end
        if (p == DEPTH - 1) fin = 1'b1;
        else p = p + 1;
      end
    end
    exp_pc = p;
    exp_end_tick = t;
  endtask

  task automatic load_entry(input int idx, input logic [14:0] w);
    @(negedge clk);
    load_en = 1'b1; load_idx = IDX_W'(idx); load_word = w;
    model_prog[idx] = w;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // start on the edge right after a tick, optionally loading an entry on that edge
  task automatic start_prog(input bit with_load, input int idx, input logic [14:0] w);
    int guard;
    guard = 0;
    cap_addr.delete(); cap_data.delete(); cap_tick.delete();
    @(negedge clk);
    while (clk_en !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    tick_base = tick_cnt;
    start = 1'b1;
    mon_on = 1'b1;
    if (with_load) begin
      load_en = 1'b1; load_idx = IDX_W'(idx); load_word = w;
      model_prog[idx] = w;
    end
    @(negedge clk);
    start = 1'b0;
    load_en = 1'b0;
    model_run(64);
  endtask

  task automatic compare_writes(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < cap_addr.size() && i < exp_addr.size()) begin
        check_val($sformatf("%s_w%0d_addr", tag, i), 32'(cap_addr[i]), 32'(exp_addr[i]));
        check_val($sformatf("%s_w%0d_data", tag, i), 32'(cap_data[i]), 32'(exp_data[i]));
        check_val($sformatf("%s_w%0d_tick", tag, i), 32'(cap_tick[i]), 32'(exp_tick[i]));
      end
    end
  endtask

  task automatic finish_check(input string tag);
    int guard, limit;
    guard = 0;
    limit = (exp_end_tick + 3) * 10 + 40;
    while (done !== 1'b1 && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_end_tick"}, 32'(tick_cnt - tick_base), 32'(exp_end_tick));
    check_val({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_nwrites"}, 32'(cap_addr.size()), 32'(exp_addr.size()));
    compare_writes(tag, exp_addr.size());
    mon_on = 1'b0;
    $display("run %s: writes=%0d end_tick=%0d pc=%0d", tag, cap_addr.size(), tick_cnt - tick_base, pc);
  endtask

  task automatic rand_prog(input bit no_end);
    int len, n;
    bit prev_w0;
    logic [14:0] w;
    prev_w0 = 1'b0;
    len = no_end ? DEPTH : int'($urandom_range(1, DEPTH));
    for (int i = 0; i < len; i++) begin
      if (!no_end && i == len - 1) begin
        w = enc(2'b11, 5'd0, 8'd0);
      end else if ($urandom_range(0, 1) == 0) begin
        w = enc(2'b00, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
        prev_w0 = 1'b0;
      end else begin
        n = prev_w0 ? int'($urandom_range(1, 5)) : int'($urandom_range(0, 5));
        w = {2'b01, 13'(n)};
        prev_w0 = (n == 0);
      end
      load_entry(i, w);
    end
  endtask

  initial begin
    int guard;
    #2 n_reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_n_cs", 32'(sid_n_cs), 32'd1);
    check_val("rst_addr", 32'(sid_addr), 32'd0);
    check_val("rst_data", 32'(sid_data), 32'd0);
    check_val("rst_pc", 32'(pc), 32'd0);
    n_reset = 1'b1;
    @(negedge clk);

    // single write then END; done must hold afterwards
    load_entry(0, enc(2'b00, 5'h18, 8'h08));
    load_entry(1, enc(2'b11, 5'd0, 8'd0));
    start_prog(1'b0, 0, '0);
    finish_check("basic");
    repeat (20) @(negedge clk);
    check_val("done_hold", 32'(done), 32'd1);

    // write, wait 5, write, END
    load_entry(0, enc(2'b00, 5'h05, 8'hBE));
    load_entry(1, {2'b01, 13'd5});
    load_entry(2, enc(2'b00, 5'h06, 8'hF8));
    load_entry(3, enc(2'b11, 5'd0, 8'd0));
    start_prog(1'b0, 0, '0);
    finish_check("wait_spacing");

    // jump beyond the table acts as END
    load_entry(0, enc(2'b10, 5'd0, 8'd20));
    start_prog(1'b0, 0, '0);
    finish_check("jump_oob");

    // entry 0 loaded on the start edge is what runs
    load_entry(0, enc(2'b11, 5'd0, 8'd0));
    load_entry(1, enc(2'b11, 5'd0, 8'd0));
    start_prog(1'b1, 0, enc(2'b00, 5'h1F, 8'hA5));
    finish_check("load_at_start");

    for (int r = 0; r < 6; r++) begin
      rand_prog(1'b0);
      start_prog(1'b0, 0, '0);
      finish_check($sformatf("rand%0d", r));
    end

    // no END anywhere: runs off the last entry
    rand_prog(1'b1);
    start_prog(1'b0, 0, '0);
    finish_check("overflow");

    // endless jump loop, then stop in the gap
    load_entry(0, enc(2'b00, 5'h04, 8'h11));
    load_entry(1, enc(2'b10, 5'd0, 8'd0));
    start_prog(1'b0, 0, '0);
    guard = 0;
    while (cap_addr.size() < 3 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    check_val("loop_nwrites", 32'(cap_addr.size()), 32'd3);
    compare_writes("loop", 3);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_val("stop_busy", 32'(busy), 32'd0);
    check_val("stop_n_cs", 32'(sid_n_cs), 32'd1);
    check_val("stop_done", 32'(done), 32'd0);
    repeat (80) @(negedge clk);
    check_val("stop_no_more_writes", 32'(cap_addr.size()), 32'd3);
    check_val("stop_still_idle", 32'(busy), 32'd0);
    mon_on = 1'b0;
    $display("run loop_stop: writes=%0d", cap_addr.size());

    // start while busy leaves pc alone
    load_entry(0, {2'b01, 13'd3});
    load_entry(1, {2'b01, 13'd4});
    load_entry(2, enc(2'b11, 5'd0, 8'd0));
    start_prog(1'b0, 0, '0);
    guard = 0;
    while (pc !== IDX_W'(1) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_start_pc", 32'(pc), 32'd1);
    check_val("busy_start_busy", 32'(busy), 32'd1);
    finish_check("busy_start");

    // load while busy must be ignored
    load_entry(0, enc(2'b00, 5'h0A, 8'h55));
    load_entry(1, {2'b01, 13'd10});
    load_entry(2, enc(2'b11, 5'd0, 8'd0));
    start_prog(1'b0, 0, '0);
    repeat (5) @(negedge clk);
    load_en = 1'b1; load_idx = '0; load_word = enc(2'b00, 5'h1B, 8'h66);
    @(negedge clk);
    load_en = 1'b0;
    finish_check("busy_load");
    start_prog(1'b0, 0, '0);
    finish_check("busy_load_rerun");

    // stop clears done; start with stop stays idle
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_val("stop_clears_done", 32'(done), 32'd0);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check_val("start_stop_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check_val("start_stop_idle", 32'(busy), 32'd0);

    // asynchronous reset during a chip-select pulse
    load_entry(0, enc(2'b00, 5'h13, 8'h77));
    load_entry(1, enc(2'b11, 5'd0, 8'd0));
    start_prog(1'b0, 0, '0);
    guard = 0;
    while (sid_n_cs !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_val("pre_reset_n_cs", 32'(sid_n_cs), 32'd0);
    mon_on = 1'b0;
    #2 n_reset = 1'b0;
    #1;
    check_val("async_rst_n_cs", 32'(sid_n_cs), 32'd1);
    check_val("async_rst_busy", 32'(busy), 32'd0);
    check_val("async_rst_addr", 32'(sid_addr), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    // table survives reset
    start_prog(1'b0, 0, '0);
    finish_check("after_reset");

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
